// File: rtl/order_tx_encoder_pkg.sv
// Shared state type, header field layout and header
// builder for the order-entry transmit encoder.
package order_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PRICE,
    QTY,
    CSUM,
    GAP
  } state_e;

  localparam int FRAME_BEATS = 4;
  localparam int MAGIC_LSB   = 48;
  localparam int ID_LSB      = 32;
  localparam int SEQ_LSB     = 8;
  localparam int SIDE_BIT    = 0;
  localparam int SEQ_W       = 24;

  localparam logic [15:0] MAGIC_DEF = 16'hA55A;

  function automatic logic [63:0] mk_hdr(
    input logic [15:0]      magic,
    input logic [15:0]      id,
    input logic [SEQ_W-1:0] seq,
    input logic             side
  );
    logic [63:0] h;
    h = '0;
    h[MAGIC_LSB +: 16]  = magic;
    h[ID_LSB +: 16]     = id;
    h[SEQ_LSB +: SEQ_W] = seq;
    h[SIDE_BIT]         = side;
    return h;
  endfunction

endpackage

// File: rtl/order_tx_encoder_if.sv
// Order request and frame transmit bundle.
// master = encoder view, slave = strategy/MAC view.
interface order_tx_encoder_if;
  import order_tx_pkg::*;

  logic [63:0]      ord_price;
  logic [63:0]      ord_qty;
  logic             ord_side;
  logic [15:0]      ord_id;
  logic             ord_valid;
  logic             ord_ready;
  logic             ord_reject;
  logic [63:0]      tx_data;
  logic             tx_valid;
  logic             tx_last;
  logic             tx_ready;
  logic [SEQ_W-1:0] tx_seq;

  modport master (
    input  ord_price, ord_qty, ord_side,
    input  ord_id, ord_valid, tx_ready,
    output ord_ready, ord_reject,
    output tx_data, tx_valid, tx_last, tx_seq
  );

  modport slave (
    output ord_price, ord_qty, ord_side,
    output ord_id, ord_valid, tx_ready,
    input  ord_ready, ord_reject,
    input  tx_data, tx_valid, tx_last, tx_seq
  );

endinterface

// File: rtl/order_tx_encoder.sv
// Serialises accepted orders into 4-beat frames with
// a wrapping sequence stamp and a forced idle gap.
module order_tx_encoder
  import order_tx_pkg::*;
#(
  parameter logic [15:0] MAGIC      = MAGIC_DEF,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  order_tx_encoder_if.master  bus
);

  localparam int GW =
    (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [63:0]      price_q, price_d;
  logic [63:0]      qty_q, qty_d;
  logic             side_q, side_d;
  logic [15:0]      id_q, id_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [63:0]      data_q, data_d;
  logic             last_q, last_d;
  logic             rej_q, rej_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      price_q <= '0;
      qty_q   <= '0;
      side_q  <= 1'b0;
      id_q    <= '0;
      seq_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      price_q <= price_d;
      qty_q   <= qty_d;
      side_q  <= side_d;
      id_q    <= id_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    price_d = price_q;
    qty_d   = qty_q;
    side_d  = side_q;
    id_d    = id_q;
    seq_d   = seq_q;
    gap_d   = gap_q;
    data_d  = data_q;
    last_d  = last_q;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ord_valid) begin
          price_d = bus.ord_price;
          qty_d   = bus.ord_qty;
          side_d  = bus.ord_side;
          id_d    = bus.ord_id;
          if (bus.ord_qty != '0) begin
            state_d = HDR;
            last_d  = 1'b0;
            data_d  = mk_hdr(MAGIC, bus.ord_id,
                             seq_q, bus.ord_side);
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (bus.tx_ready) begin
          state_d = PRICE;
          data_d  = price_q;
        end
      end
      PRICE: begin
        if (bus.tx_ready) begin
          state_d = QTY;
          data_d  = qty_q;
        end
      end
      QTY: begin
        if (bus.tx_ready) begin
          state_d = CSUM;
          last_d  = 1'b1;
          data_d  = mk_hdr(MAGIC, id_q, seq_q, side_q)
                    ^ price_q ^ qty_q;
        end
      end
      CSUM: begin
        if (bus.tx_ready) begin
          seq_d   = seq_q + SEQ_W'(1);
          last_d  = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // valid/ready come straight off the state register
  assign bus.ord_ready  = (state_q == IDLE);
  assign bus.ord_reject = rej_q;
  assign bus.tx_valid   = (state_q == HDR)   ||
                          (state_q == PRICE) ||
                          (state_q == QTY)   ||
                          (state_q == CSUM);
  assign bus.tx_data    = data_q;
  assign bus.tx_last    = last_q;
  assign bus.tx_seq     = seq_q;

endmodule

// File: tb/tb_order_tx_encoder.sv
// Bench for order_tx_encoder: table vectors, corner
// sequences and random orders against a frame model.
module tb_order_tx_encoder;
  import order_tx_pkg::*;

  localparam int GAPC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  order_tx_encoder_if a_if ();
  order_tx_encoder_if z_if ();

  order_tx_encoder #(
    .MAGIC(16'hA55A),
    .GAP_CYCLES(GAPC)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(a_if)
  );

  order_tx_encoder #(
    .MAGIC(16'hA55A),
    .GAP_CYCLES(0)
  ) u_dut0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(z_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int m_seq = 0;

  typedef struct {
    logic [63:0] price;
    logic [63:0] qty;
    logic        side;
    logic [15:0] id;
    int          mode;
    logic        exp_rej;
    logic [63:0] exp_hdr;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_beat(
    input int k,
    input logic [63:0] price,
    input logic [63:0] qty,
    input logic side,
    input logic [15:0] id,
    input int seq
  );
    logic [63:0] hdr;
    hdr = (64'hA55A << 48) | (64'(id) << 32)
        | (64'(seq) << 8) | 64'(side);
    case (k)
      0: return hdr;
      1: return price;
      2: return qty;
      default: return hdr ^ price ^ qty;
    endcase
  endfunction

  task automatic run_order(input logic [63:0] price,
                           input logic [63:0] qty,
                           input logic side,
                           input logic [15:0] id,
                           input int mode,
                           input logic exp_rej,
                           input logic [63:0] exp_hdr,
                           input bit use_hdr);
    logic [63:0] eb[4];
    logic [63:0] hd;
    int w, nb, bp, gap;
    bit held, gap_bad, r;
    for (int k = 0; k < 4; k++)
      eb[k] = model_beat(k, price, qty, side, id, m_seq);
    w = 0;
    while (!a_if.ord_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", 64'(a_if.ord_ready), 64'd1);
    a_if.ord_price = price;
    a_if.ord_qty   = qty;
    a_if.ord_side  = side;
    a_if.ord_id    = id;
    a_if.ord_valid = 1'b1;
    a_if.tx_ready  = 1'b1;
    @(negedge clk);
    a_if.ord_valid = 1'b0;
    chk("ready_after_accept", 64'(a_if.ord_ready),
        64'(exp_rej));
    chk("reject_pulse", 64'(a_if.ord_reject), 64'(exp_rej));
    if (exp_rej) begin
      chk("reject_no_valid", 64'(a_if.tx_valid), 64'd0);
      chk("reject_seq_hold", 64'(a_if.tx_seq), 64'(m_seq));
      @(negedge clk);
      chk("reject_once", 64'(a_if.ord_reject), 64'd0);
      chk("reject_no_valid2", 64'(a_if.tx_valid), 64'd0);
      return;
    end
    chk("hdr_latency", 64'(a_if.tx_valid), 64'd1);
    nb = 0;
    bp = 0;
    w = 0;
    held = 0;
    hd = '0;
    while (nb < 4 && w < 60) begin
      if (!a_if.tx_valid) begin
        chk("valid_mid_frame", 64'd0, 64'd1);
        break;
      end
      if (held) chk("hold_stable", a_if.tx_data, hd);
      case (mode)
        1: r = !(nb == 1 && bp < 3);
        2: r = ($urandom_range(0, 2) != 0);
        default: r = 1'b1;
      endcase
      if (!r) bp++;
      a_if.tx_ready = r;
      if (r) begin
        chk($sformatf("beat%0d", nb), a_if.tx_data, eb[nb]);
        chk($sformatf("last%0d", nb), 64'(a_if.tx_last),
            64'(nb == 3));
        if (nb == 0 && use_hdr)
          chk("hdr_const", a_if.tx_data, exp_hdr);
        nb++;
        held = 0;
      end else begin
        held = 1;
        hd = a_if.tx_data;
      end
      @(negedge clk);
      w++;
    end
    if (nb < 4) chk("frame_done", 64'(nb), 64'd4);
    a_if.tx_ready = 1'b1;
    gap = 0;
    gap_bad = 0;
    while (!a_if.ord_ready && gap < 30) begin
      if (a_if.tx_valid) gap_bad = 1;
      gap++;
      @(negedge clk);
    end
    chk("gap_len", 64'(gap), 64'(GAPC));
    chk("gap_quiet", 64'(gap_bad), 64'd0);
    m_seq = (m_seq + 1) % (1 << 24);
    chk("seq_after", 64'(a_if.tx_seq), 64'(m_seq));
  endtask

  initial begin
    int cyc, vc, hc, w;
    int hcyc[3];
    int hseq[3];
    logic [63:0] p, q;

    a_if.ord_price = '0;
    a_if.ord_qty   = '0;
    a_if.ord_side  = 1'b0;
    a_if.ord_id    = '0;
    a_if.ord_valid = 1'b0;
    a_if.tx_ready  = 1'b1;
    z_if.ord_price = '0;
    z_if.ord_qty   = '0;
    z_if.ord_side  = 1'b0;
    z_if.ord_id    = '0;
    z_if.ord_valid = 1'b0;
    z_if.tx_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(a_if.ord_ready), 64'd1);
    chk("rst_reject", 64'(a_if.ord_reject), 64'd0);
    chk("rst_valid", 64'(a_if.tx_valid), 64'd0);
    chk("rst_last", 64'(a_if.tx_last), 64'd0);
    chk("rst_data", a_if.tx_data, 64'd0);
    chk("rst_seq", 64'(a_if.tx_seq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{64'd100, 64'd5, 1'b0, 16'h0001, 0, 1'b0,
               64'hA55A_0001_0000_0000};
    tbl[1] = '{64'd7, 64'd0, 1'b1, 16'h0002, 0, 1'b1,
               64'h0};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
               16'hBEEF, 0, 1'b0, 64'hA55A_BEEF_0000_0101};
    tbl[3] = '{64'd0, 64'h8000_0000_0000_0000, 1'b0,
               16'hFFFF, 1, 1'b0, 64'hA55A_FFFF_0000_0200};
    for (int i = 0; i < 4; i++)
      run_order(tbl[i].price, tbl[i].qty, tbl[i].side,
                tbl[i].id, tbl[i].mode, tbl[i].exp_rej,
                tbl[i].exp_hdr, !tbl[i].exp_rej);

    // sequence wrap: preset the counter just below rollover
    force u_dut.seq_q = 24'hFFFFFF;
    @(posedge clk);
    #1 release u_dut.seq_q;
    m_seq = 24'hFFFFFF;
    @(negedge clk);
    chk("wrap_preload", 64'(a_if.tx_seq), 64'hFFFFFF);
    run_order(64'd3, 64'd4, 1'b0, 16'h0007, 0, 1'b0,
              64'hA55A_0007_FFFF_FF00, 1'b1);
    run_order(64'd9, 64'd2, 1'b1, 16'h0008, 0, 1'b0,
              64'hA55A_0008_0000_0001, 1'b1);

    // reset in the middle of the QTY beat
    run_order(64'd1, 64'd1, 1'b0, 16'h0010, 0, 1'b0,
              64'h0, 1'b0);
    a_if.ord_price = 64'd11;
    a_if.ord_qty   = 64'd22;
    a_if.ord_side  = 1'b1;
    a_if.ord_id    = 16'h0ABC;
    a_if.ord_valid = 1'b1;
    @(negedge clk);
    a_if.ord_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("qty_beat", a_if.tx_data, 64'd22);
    chk("qty_valid", 64'(a_if.tx_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_if.tx_valid), 64'd0);
    chk("arst_last", 64'(a_if.tx_last), 64'd0);
    chk("arst_seq", 64'(a_if.tx_seq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 64'(a_if.ord_ready), 64'd1);
    m_seq = 0;
    run_order(64'd44, 64'd55, 1'b0, 16'h0033, 0, 1'b0,
              64'hA55A_0033_0000_0000, 1'b1);

    // back-to-back requests with no gap
    z_if.ord_price = 64'd5;
    z_if.ord_qty   = 64'd9;
    z_if.ord_side  = 1'b0;
    z_if.ord_id    = 16'h0055;
    z_if.ord_valid = 1'b1;
    cyc = 0;
    vc = 0;
    hc = 0;
    while (hc < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (z_if.tx_valid) begin
        if (vc % 4 == 0) begin
          hcyc[hc] = cyc;
          hseq[hc] = int'(z_if.tx_data[31:8]);
          hc++;
        end
        vc++;
      end
    end
    z_if.ord_valid = 1'b0;
    chk("b2b_frames", 64'(hc), 64'd3);
    if (hc == 3) begin
      chk("b2b_period1", 64'(hcyc[1] - hcyc[0]), 64'd5);
      chk("b2b_period2", 64'(hcyc[2] - hcyc[1]), 64'd5);
      for (int i = 0; i < 3; i++)
        chk($sformatf("b2b_seq%0d", i), 64'(hseq[i]),
            64'(i));
    end

    for (int i = 0; i < 20; i++) begin
      p = {$urandom, $urandom};
      q = ($urandom_range(0, 5) == 0) ? 64'd0
                                       : {$urandom, $urandom};
      run_order(p, q, 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 2,
                (q == 64'd0), 64'h0, 1'b0);
    end

    w = 0;
    while (!z_if.ord_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
